// File: rtl/rptr_empty_if.sv
// Read-side handshake of the async FIFO: pop request and synchronized write
// pointer in, RAM address plus Gray pointer and flags out.
interface rptr_empty_if #(
    parameter int ADDRSIZE = 4
);
    logic                rinc;
    logic [ADDRSIZE:0]   rq2_wptr;
    logic [ADDRSIZE-1:0] raddr;
    logic [ADDRSIZE:0]   rptr;
    logic                rempty;
    logic                arempty;
    logic [ADDRSIZE:0]   rlevel;

    modport master (
        output rinc, rq2_wptr,
        input  raddr, rptr, rempty, arempty, rlevel
    );

    modport slave (
        input  rinc, rq2_wptr,
        output raddr, rptr, rempty, arempty, rlevel
    );
endinterface

// File: rtl/rptr_empty.sv
// Read-domain pointer and empty/almost-empty/occupancy controller of the async FIFO.
// Flags are computed from the next-state pointer so a pop is reflected on the same edge.
module rptr_empty #(
    parameter int ADDRSIZE           = 4,
    parameter int ALMOST_EMPTY_LEVEL = 1
) (
    input  logic          rclk,
    input  logic          rrst_n,
    rptr_empty_if.slave   rif
);
    localparam logic [ADDRSIZE+1:0] AE_LVL = ALMOST_EMPTY_LEVEL[ADDRSIZE+1:0];

    logic [ADDRSIZE:0] rbin_q, rbin_d;
    logic [ADDRSIZE:0] rptr_q, rptr_d;
    logic [ADDRSIZE:0] rlevel_q, rlevel_d;
    logic              rempty_q, rempty_d;
    logic              arempty_q, arempty_d;
    logic [ADDRSIZE:0] wbin;
    logic              pop;

    // Gray-to-binary: each bit is the XOR of all Gray bits at or above it
    for (genvar i = 0; i <= ADDRSIZE; i++) begin : g_g2b
        assign wbin[i] = ^rif.rq2_wptr[ADDRSIZE:i];
    end

    // A request while empty is dropped so the pointer can never pass the writer
    assign pop = rif.rinc & ~rempty_q;

    always_comb begin
        rbin_d    = rbin_q + {{ADDRSIZE{1'b0}}, pop};
        rptr_d    = (rbin_d >> 1) ^ rbin_d;
        rempty_d  = (rptr_d == rif.rq2_wptr);
        rlevel_d  = wbin - rbin_d;
        arempty_d = ({1'b0, rlevel_d} <= AE_LVL);
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin_q    <= '0;
            rptr_q    <= '0;
            rlevel_q  <= '0;
            rempty_q  <= 1'b1;
            arempty_q <= 1'b1;
        end else begin
            rbin_q    <= rbin_d;
            rptr_q    <= rptr_d;
            rlevel_q  <= rlevel_d;
            rempty_q  <= rempty_d;
            arempty_q <= arempty_d;
        end
    end

    assign rif.raddr   = rbin_q[ADDRSIZE-1:0];
    assign rif.rptr    = rptr_q;
    assign rif.rlevel  = rlevel_q;
    assign rif.rempty  = rempty_q;
    assign rif.arempty = arempty_q;
endmodule

// File: tb/tb_rptr_empty.sv
// Bench for rptr_empty: hand-derived vector table, directed corner sequences and
// random pops/writes checked against an occupancy model built on plain read/write counts.
module tb_rptr_empty;
    localparam int AW    = 4;
    localparam int AEL   = 2;
    localparam int DEPTH = 16;
    localparam int PW    = AW + 1;

    logic rclk   = 1'b0;
    logic rrst_n = 1'b0;

    rptr_empty_if #(.ADDRSIZE(AW)) rif ();

    rptr_empty #(.ADDRSIZE(AW), .ALMOST_EMPTY_LEVEL(AEL)) dut (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .rif    (rif)
    );

    always #5 rclk = ~rclk;

    int checks = 0;
    int errors = 0;

    // Model: total entries read and total entries the writer has published
    int m_r;
    int m_w;
    bit m_empty;

    typedef struct {
        bit inc;
        int w;
        bit e;
        bit ae;
        int lvl;
        int ra;
        int rp;
    } vec_t;

    vec_t tbl[10];

    function automatic logic [PW-1:0] gray(input int n);
        logic [PW-1:0] b;
        b = PW'(n);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        int occ;
        occ = m_w - m_r;
        chk({tag, " rempty"},  int'(rif.rempty),  int'(occ == 0));
        chk({tag, " arempty"}, int'(rif.arempty), int'(occ <= AEL));
        chk({tag, " rlevel"},  int'(rif.rlevel),  occ);
        chk({tag, " raddr"},   int'(rif.raddr),   m_r % DEPTH);
        chk({tag, " rptr"},    int'(rif.rptr),    int'(gray(m_r)));
    endtask

    task automatic model_reset();
        m_r     = 0;
        m_w     = 0;
        m_empty = 1'b1;
    endtask

    task automatic step(input bit inc, input int w, input string tag);
        rif.rinc     = inc;
        rif.rq2_wptr = gray(w);
        @(posedge rclk);
        if (rrst_n) begin
            if (inc && !m_empty) m_r++;
            m_w     = w;
            m_empty = ((m_w - m_r) == 0);
        end
        #1;
        check_model(tag);
    endtask

    // Called just after a checked edge: reset lands well before the next edge
    task automatic do_reset(input string tag);
        #3 rrst_n = 1'b0;
        #1;
        model_reset();
        check_model(tag);
        rif.rinc     = 1'b0;
        rif.rq2_wptr = '0;
        @(negedge rclk);
        rrst_n = 1'b1;
    endtask

    initial begin
        logic [PW-1:0] prev;
        int dw, cap;

        tbl[0] = '{0, 1, 0, 1, 1, 0, 0};
        tbl[1] = '{1, 1, 1, 1, 0, 1, 1};
        tbl[2] = '{1, 1, 1, 1, 0, 1, 1};
        tbl[3] = '{0, 2, 0, 1, 1, 1, 1};
        tbl[4] = '{1, 3, 0, 1, 1, 2, 3};
        tbl[5] = '{0, 6, 0, 0, 4, 2, 3};
        tbl[6] = '{1, 6, 0, 0, 3, 3, 2};
        tbl[7] = '{1, 6, 0, 1, 2, 4, 6};
        tbl[8] = '{1, 6, 0, 1, 1, 5, 7};
        tbl[9] = '{1, 6, 1, 1, 0, 6, 5};

        // Reset held with activity on the inputs
        model_reset();
        rif.rinc     = 1'b1;
        rif.rq2_wptr = 5'b00011;
        repeat (3) begin
            @(posedge rclk);
            #1 check_model("rst_hold");
        end
        @(negedge rclk);
        rrst_n = 1'b1;
        #1 check_model("rst_release");
        step(1'b1, 2, "post_rst");

        // Single entry, simultaneous pop+write, drain and underflow
        do_reset("rst_tbl");
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].inc, tbl[i].w, "tbl_model");
            chk("tbl rempty",  int'(rif.rempty),  int'(tbl[i].e));
            chk("tbl arempty", int'(rif.arempty), int'(tbl[i].ae));
            chk("tbl rlevel",  int'(rif.rlevel),  tbl[i].lvl);
            chk("tbl raddr",   int'(rif.raddr),   tbl[i].ra);
            chk("tbl rptr",    int'(rif.rptr),    tbl[i].rp);
        end
        repeat (10) step(1'b1, 6, "underflow");
        chk("underflow rptr",  int'(rif.rptr),  5);
        chk("underflow raddr", int'(rif.raddr), 6);

        // Wrap: 40 writes popped back-to-back
        do_reset("rst_wrap");
        for (int i = 1; i <= 41; i++) begin
            prev = rif.rptr;
            step(1'b1, (i > 40) ? 40 : i, "wrap");
            chk("wrap gray_onebit", int'($countones(prev ^ rif.rptr) <= 1), 1);
            chk("wrap empty_eq", int'(rif.rempty), int'(rif.rptr == rif.rq2_wptr));
        end
        chk("wrap total_pops", m_r, 40);
        chk("wrap final_raddr", int'(rif.raddr), 8);

        // Almost-empty threshold
        do_reset("rst_ae");
        step(1'b0, 16, "ae_full");
        chk("ae full rlevel",  int'(rif.rlevel),  16);
        chk("ae full arempty", int'(rif.arempty), 0);
        repeat (13) step(1'b1, 16, "ae_pop");
        chk("ae lvl3 rlevel",  int'(rif.rlevel),  3);
        chk("ae lvl3 arempty", int'(rif.arempty), 0);
        step(1'b1, 16, "ae_pop");
        chk("ae lvl2 rlevel",  int'(rif.rlevel),  2);
        chk("ae lvl2 arempty", int'(rif.arempty), 1);

        // Random traffic with an asynchronous reset mid-burst
        do_reset("rst_rand");
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset("rst_midburst");
            cap = m_r + DEPTH - m_w;
            dw  = int'($urandom_range(0, 2));
            if (dw > cap) dw = cap;
            step(1'($urandom_range(0, 1)), m_w + dw, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
